// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman front end: symbol codes,
// feeder FSM states and datapath widths.
package sw_pkg;

  localparam int ADDR_W  = 13;
  localparam int SCORE_W = 16;
  localparam int LEN_W   = 16;
  localparam int SYM_W   = 3;

  // Code 0 marks an idle cycle on either symbol bus.
  localparam logic [SYM_W-1:0] SYM_NONE = 3'd0;
  localparam logic [SYM_W-1:0] SYM_A    = 3'd1;
  localparam logic [SYM_W-1:0] SYM_C    = 3'd2;
  localparam logic [SYM_W-1:0] SYM_G    = 3'd3;
  localparam logic [SYM_W-1:0] SYM_T    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLR      = 3'd1,
    ST_LOAD_S   = 3'd2,
    ST_WAIT_T   = 3'd3,
    ST_LOAD_T   = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_WAIT_RES = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  // A run is legal when S fits the systolic array and both sequences are non-empty.
  function automatic logic lengths_legal(input logic [LEN_W-1:0] s_len,
                                         input logic [LEN_W-1:0] t_len,
                                         input logic [LEN_W-1:0] n_max);
    return (s_len != '0) && (s_len <= n_max) && (t_len != '0);
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Sequence address generator: walks base+index for len symbols, one read
// per enabled cycle. Re-based between the S and T passes by pulsing load.
module seq_addr_gen
  import sw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              gate,
  output logic              ce,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic              active;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  last_idx;

  assign last_idx = len_q - LEN_W'(1);
  assign ce       = active && gate;
  // Address wraps at the top of the 8K SRAM; the upper index bits only feed the last compare.
  assign addr     = base_q + idx[ADDR_W-1:0];
  assign last     = active && (idx == last_idx);

  // Load a new base/length, then advance the index on every issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      idx    <= '0;
    end else if (load) begin
      active <= 1'b1;
      base_q <= base;
      len_q  <= len;
      idx    <= '0;
    end else if (ce) begin
      if (last) begin
        active <= 1'b0;
      end else begin
        idx <= idx + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_feeder.sv
// Sequence feeder: reads S then T from the sequence SRAM, streams one symbol
// per cycle into the Smith-Waterman core and latches the core's max score.
//
// T handshake: core_t_valid_in_i acts as ready for the T stream. A T read is
// issued only in a cycle where it is high; the symbol from that read lands on
// core_t_o the following cycle regardless of the ready level then, so the core
// must absorb at most one symbol after dropping ready. core_s_o and core_t_o
// carry SYM_NONE in every cycle without a symbol.
module seq_feeder
  import sw_pkg::*;
#(
  parameter int                N      = 50,
  parameter logic [ADDR_W-1:0] S_BASE = 13'd0,
  parameter logic [ADDR_W-1:0] T_BASE = 13'd64
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   s_len_i,
  input  logic [LEN_W-1:0]   t_len_i,
  output logic               mem_ce_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic [7:0]         mem_rdata_i,
  output logic               core_clr_o,
  output logic [SYM_W-1:0]   core_s_o,
  output logic [SYM_W-1:0]   core_t_o,
  output logic [LEN_W-1:0]   core_s_len_o,
  output logic [LEN_W-1:0]   core_t_len_o,
  input  logic               core_t_valid_in_i,
  input  logic               core_busy_i,
  input  logic               core_valid_i,
  input  logic [SCORE_W-1:0] core_max_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [SCORE_W-1:0] score_o,
  output state_t             dbg_state_o
);

  state_t            state;
  logic [LEN_W-1:0]  s_len_q;
  logic [LEN_W-1:0]  t_len_q;
  logic              s_pend;
  logic              t_pend;
  logic              ag_load;
  logic [ADDR_W-1:0] ag_base;
  logic [LEN_W-1:0]  ag_len;
  logic              ag_gate;
  logic              ag_ce;
  logic              ag_last;
  logic              unused_rdata_bits;

  // The generator is armed for S while clearing the core and for T while waiting on the core.
  assign ag_load = (state == ST_CLR) || (state == ST_WAIT_T);
  assign ag_base = (state == ST_CLR) ? S_BASE : T_BASE;
  assign ag_len  = (state == ST_CLR) ? s_len_q : t_len_q;
  assign ag_gate = (state == ST_LOAD_S) || ((state == ST_LOAD_T) && core_t_valid_in_i);

  seq_addr_gen u_addr_gen (
    .clk   (clk),
    .rst_n (reset_i),
    .load  (ag_load),
    .base  (ag_base),
    .len   (ag_len),
    .gate  (ag_gate),
    .ce    (ag_ce),
    .addr  (mem_addr_o),
    .last  (ag_last)
  );

  assign mem_ce_o = ag_ce;

  // SRAM output is already registered; the pending flags steer it onto the right bus for one cycle.
  assign core_s_o          = s_pend ? mem_rdata_i[SYM_W-1:0] : SYM_NONE;
  assign core_t_o          = t_pend ? mem_rdata_i[SYM_W-1:0] : SYM_NONE;
  assign unused_rdata_bits = ^mem_rdata_i[7:SYM_W];

  assign core_s_len_o = s_len_q;
  assign core_t_len_o = t_len_q;
  assign dbg_state_o  = state;

  // Run sequencing with registered control outputs and result capture.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state      <= ST_IDLE;
      s_len_q    <= '0;
      t_len_q    <= '0;
      s_pend     <= 1'b0;
      t_pend     <= 1'b0;
      core_clr_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
      score_o    <= '0;
    end else begin
      core_clr_o <= 1'b0;
      done_o     <= 1'b0;
      s_pend     <= ag_ce && (state == ST_LOAD_S);
      t_pend     <= ag_ce && (state == ST_LOAD_T);
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (lengths_legal(s_len_i, t_len_i, LEN_W'(N))) begin
              s_len_q    <= s_len_i;
              t_len_q    <= t_len_i;
              err_o      <= 1'b0;
              core_clr_o <= 1'b1;
              busy_o     <= 1'b1;
              state      <= ST_CLR;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_CLR:    state <= ST_LOAD_S;
        ST_LOAD_S: if (ag_ce && ag_last) state <= ST_WAIT_T;
        ST_WAIT_T: if (core_t_valid_in_i) state <= ST_LOAD_T;
        ST_LOAD_T: if (ag_ce && ag_last) state <= ST_DRAIN;
        ST_DRAIN:  state <= ST_WAIT_RES;
        ST_WAIT_RES: begin
          if (core_valid_i && !core_busy_i) begin
            score_o <= core_max_i;
            done_o  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_feeder.sv
// Directed bench for seq_feeder: table of full runs plus hand-written
// sequences for T backpressure, address wrap and asynchronous reset.
module tb_seq_feeder;
  import sw_pkg::*;

  localparam logic [12:0] S_B  = 13'd0;
  localparam logic [12:0] T_B  = 13'd64;
  localparam logic [12:0] W_TB = 13'd8190;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start_i = 1'b0;
  logic [15:0] s_len_i = '0, t_len_i = '0;
  logic        core_t_valid_in_i = 1'b1, core_busy_i = 1'b1, core_valid_i = 1'b0;
  logic [15:0] core_max_i = '0;
  logic        mem_ce_o, core_clr_o, busy_o, done_o, err_o;
  logic [12:0] mem_addr_o;
  logic [7:0]  mem_rdata;
  logic [2:0]  core_s_o, core_t_o;
  logic [15:0] core_s_len_o, core_t_len_o, score_o;
  state_t      dbg_state_o;
  logic        w_ce, w_clr, w_busy, w_done, w_err;
  logic [12:0] w_addr;
  logic [7:0]  w_rdata;
  logic [2:0]  w_s, w_t;
  logic [15:0] w_slen, w_tlen, w_score;
  state_t      w_state;

  seq_feeder #(.N(50), .S_BASE(S_B), .T_BASE(T_B)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i), .s_len_i(s_len_i), .t_len_i(t_len_i),
    .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata),
    .core_clr_o(core_clr_o), .core_s_o(core_s_o), .core_t_o(core_t_o),
    .core_s_len_o(core_s_len_o), .core_t_len_o(core_t_len_o),
    .core_t_valid_in_i(core_t_valid_in_i), .core_busy_i(core_busy_i),
    .core_valid_i(core_valid_i), .core_max_i(core_max_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .score_o(score_o),
    .dbg_state_o(dbg_state_o)
  );

  // Second instance with T based near the top of the SRAM to exercise wrap.
  seq_feeder #(.N(50), .S_BASE(S_B), .T_BASE(W_TB)) u_wrap (
    .clk(clk), .reset_i(reset_i), .start_i(start_i), .s_len_i(s_len_i), .t_len_i(t_len_i),
    .mem_ce_o(w_ce), .mem_addr_o(w_addr), .mem_rdata_i(w_rdata),
    .core_clr_o(w_clr), .core_s_o(w_s), .core_t_o(w_t),
    .core_s_len_o(w_slen), .core_t_len_o(w_tlen),
    .core_t_valid_in_i(core_t_valid_in_i), .core_busy_i(core_busy_i),
    .core_valid_i(core_valid_i), .core_max_i(core_max_i),
    .busy_o(w_busy), .done_o(w_done), .err_o(w_err), .score_o(w_score),
    .dbg_state_o(w_state)
  );

  // ---------------- SRAM model (1-cycle read latency) ----------------
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (mem_ce_o) mem_rdata <= mem[mem_addr_o];
    if (w_ce) w_rdata <= mem[w_addr];
  end

  // ---------------- monitor ----------------
  typedef struct { int cyc; logic [2:0] sym; } ev_t;
  ev_t         s_q[$], t_q[$];
  ev_t         ev;
  logic [12:0] addr_q[$], w_addr_q[$];
  int          clr_q[$];
  int          done_cnt = 0, busy_cnt = 0, both_cnt = 0;
  logic [12:0] addr_hist[int];
  logic        ce_hist[int];

  always @(negedge clk) begin
    if (core_s_o != 3'd0) begin ev.cyc = cyc; ev.sym = core_s_o; s_q.push_back(ev); end
    if (core_t_o != 3'd0) begin ev.cyc = cyc; ev.sym = core_t_o; t_q.push_back(ev); end
    if (core_s_o != 3'd0 && core_t_o != 3'd0) both_cnt++;
    if (mem_ce_o) addr_q.push_back(mem_addr_o);
    if (w_ce) w_addr_q.push_back(w_addr);
    if (core_clr_o) clr_q.push_back(cyc);
    if (done_o) done_cnt++;
    if (busy_o) busy_cnt++;
    addr_hist[cyc] = mem_addr_o;
    ce_hist[cyc]   = mem_ce_o;
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0, n_fail = 0;
  logic [12:0] exp_q[$];
  int          last_c0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic run(input int sl, input int tl, input logic [15:0] mx, input logic [63:0] tv,
                     input logic exp_err, input bit restart, input string nm);
    int c0, after_t;
    bit got_done;
    s_q.delete(); t_q.delete(); addr_q.delete(); w_addr_q.delete(); clr_q.delete();
    done_cnt = 0; busy_cnt = 0; both_cnt = 0;
    core_t_valid_in_i = 1'b1;
    start_i = 1'b1; s_len_i = 16'(sl); t_len_i = 16'(tl);
    c0 = cyc; last_c0 = c0;
    step();
    start_i = 1'b0;
    if (exp_err) begin
      repeat (4) step();
      chk({nm, ".err"}, err_o, 1);
      chk({nm, ".busy_cnt"}, busy_cnt, 0);
      chk({nm, ".reads"}, addr_q.size(), 0);
      chk({nm, ".done_cnt"}, done_cnt, 0);
      chk({nm, ".clr_cnt"}, clr_q.size(), 0);
      return;
    end
    after_t = 0; got_done = 0;
    for (int off = 1; off < 300 && !got_done; off++) begin
      core_t_valid_in_i = (off < 64) ? tv[off] : 1'b1;
      core_valid_i = 1'b0; core_busy_i = 1'b1; core_max_i = '0;
      start_i = 1'b0;
      // Result offered early (during the S pass) must be ignored.
      if (off == 4) begin core_valid_i = 1'b1; core_busy_i = 1'b0; core_max_i = 16'h0bad; end
      if (restart && off == 4) begin start_i = 1'b1; s_len_i = 16'd2; t_len_i = 16'd3; end
      if (off == 6) begin
        chk({nm, ".s_len"}, core_s_len_o, sl);
        chk({nm, ".t_len"}, core_t_len_o, tl);
      end
      if (t_q.size() == tl) after_t++;
      if (after_t == 3) begin core_valid_i = 1'b1; core_busy_i = 1'b1; core_max_i = mx + 16'd1; end
      if (after_t >= 4) begin core_valid_i = 1'b1; core_busy_i = 1'b0; core_max_i = mx; end
      step();
      if (done_cnt != 0) got_done = 1;
    end
    core_valid_i = 1'b0; core_busy_i = 1'b1; start_i = 1'b0;
    chk({nm, ".done_seen"}, got_done, 1);
    repeat (2) step();
    chk({nm, ".done_cnt"}, done_cnt, 1);
    chk({nm, ".score"}, score_o, mx);
    chk({nm, ".busy_end"}, busy_o, 0);
    chk({nm, ".err"}, err_o, 0);
    chk({nm, ".both"}, both_cnt, 0);
    chk({nm, ".clr_cnt"}, clr_q.size(), 1);
    if (clr_q.size() > 0) chk({nm, ".clr_cyc"}, clr_q[0], c0 + 1);
    chk({nm, ".s_cnt"}, s_q.size(), sl);
    for (int i = 0; i < sl && i < s_q.size(); i++) begin
      chk($sformatf("%s.s_sym%0d", nm, i), s_q[i].sym, mem[13'(S_B + i)][2:0]);
      chk($sformatf("%s.s_cyc%0d", nm, i), s_q[i].cyc, c0 + 3 + i);
    end
    chk({nm, ".t_cnt"}, t_q.size(), tl);
    for (int j = 0; j < tl && j < t_q.size(); j++) begin
      chk($sformatf("%s.t_sym%0d", nm, j), t_q[j].sym, mem[13'(T_B + j)][2:0]);
      if (tv == '1) chk($sformatf("%s.t_cyc%0d", nm, j), t_q[j].cyc, c0 + 4 + sl + j);
    end
    exp_q.delete();
    for (int i = 0; i < sl; i++) exp_q.push_back(13'(S_B + i));
    for (int j = 0; j < tl; j++) exp_q.push_back(13'(T_B + j));
    chk({nm, ".addr_cnt"}, addr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++)
      chk($sformatf("%s.addr%0d", nm, i), addr_q[i], exp_q[i]);
  endtask

  // ---------------- test ----------------
  typedef struct {
    int          sl;
    int          tl;
    logic [15:0] mx;
    logic [63:0] tv;
    logic        exp_err;
    bit          restart;
    string       nm;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int c0;
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    mem[0] = {5'h15, SYM_A}; mem[1] = {5'h0a, SYM_C};
    mem[2] = {5'h1f, SYM_G}; mem[3] = {5'h00, SYM_T};
    for (int a = 4; a < 50; a++) mem[a] = {5'(a), 3'((a * 3) % 4 + 1)};
    mem[64] = {5'h11, SYM_T}; mem[65] = {5'h02, SYM_G}; mem[66] = {5'h1c, SYM_C};
    mem[67] = {5'h00, SYM_A}; mem[68] = {5'h07, SYM_A}; mem[69] = {5'h1b, SYM_C};
    for (int a = 70; a < 80; a++) mem[a] = {5'(a), 3'((a * 7) % 4 + 1)};

    vecs[0] = '{4,  6, 16'd7,    '1, 1'b0, 1'b0, "main"};
    vecs[1] = '{51, 5, 16'd0,    '1, 1'b1, 1'b0, "s_len51"};
    vecs[2] = '{0,  5, 16'd0,    '1, 1'b1, 1'b0, "s_len0"};
    vecs[3] = '{4,  0, 16'd0,    '1, 1'b1, 1'b0, "t_len0"};
    vecs[4] = '{1,  1, 16'd1,    '1, 1'b0, 1'b0, "min_after_err"};
    vecs[5] = '{50, 3, 16'hffff, '1, 1'b0, 1'b0, "s_len50"};
    vecs[6] = '{8,  5, 16'd33,   '1, 1'b0, 1'b1, "restart_ignored"};

    // Reset values, checked while reset is held.
    #1;
    chk("rst.busy", busy_o, 0);     chk("rst.ce", mem_ce_o, 0);
    chk("rst.addr", mem_addr_o, 0); chk("rst.clr", core_clr_o, 0);
    chk("rst.done", done_o, 0);     chk("rst.err", err_o, 0);
    chk("rst.s", core_s_o, 0);      chk("rst.t", core_t_o, 0);
    chk("rst.score", score_o, 0);   chk("rst.state", dbg_state_o, ST_IDLE);
    repeat (3) step();
    reset_i = 1'b1;
    repeat (2) step();

    for (int v = 0; v < 7; v++)
      run(vecs[v].sl, vecs[v].tl, vecs[v].mx, vecs[v].tv, vecs[v].exp_err, vecs[v].restart, vecs[v].nm);

    // T backpressure: ready 1,0,0,1 from the first LOAD_T cycle.
    run(4, 6, 16'd12, ~64'h300, 1'b0, 1'b0, "toggle");
    c0 = last_c0;
    if (t_q.size() >= 2) begin
      chk("toggle.inflight_cyc", t_q[0].cyc, c0 + 8);
      chk("toggle.resume_cyc", t_q[1].cyc, c0 + 11);
    end else chk("toggle.t_present", t_q.size(), 6);
    chk("toggle.ce_low8", ce_hist[c0 + 8], 0);
    chk("toggle.ce_low9", ce_hist[c0 + 9], 0);
    chk("toggle.addr_hold8", addr_hist[c0 + 8], T_B + 13'd1);
    chk("toggle.addr_hold9", addr_hist[c0 + 9], T_B + 13'd1);
    chk("toggle.addr_go10", addr_hist[c0 + 10], T_B + 13'd1);

    // Address wrap on the instance based at 8190.
    run(2, 4, 16'd9, '1, 1'b0, 1'b0, "wrap_run");
    exp_q.delete();
    exp_q.push_back(13'd0); exp_q.push_back(13'd1);
    exp_q.push_back(13'd8190); exp_q.push_back(13'd8191);
    exp_q.push_back(13'd0); exp_q.push_back(13'd1);
    chk("wrap.cnt", w_addr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < w_addr_q.size(); i++)
      chk($sformatf("wrap.addr%0d", i), w_addr_q[i], exp_q[i]);

    // Asynchronous reset in the middle of LOAD_T.
    core_t_valid_in_i = 1'b1;
    start_i = 1'b1; s_len_i = 16'd4; t_len_i = 16'd6;
    step();
    start_i = 1'b0;
    repeat (8) step();
    chk("mid.busy", busy_o, 1);
    chk("mid.ce", mem_ce_o, 1);
    chk("mid.state", dbg_state_o, ST_LOAD_T);
    #2 reset_i = 1'b0;
    #1;
    chk("arst.busy", busy_o, 0);      chk("arst.ce", mem_ce_o, 0);
    chk("arst.addr", mem_addr_o, 0);  chk("arst.clr", core_clr_o, 0);
    chk("arst.done", done_o, 0);      chk("arst.err", err_o, 0);
    chk("arst.s", core_s_o, 0);       chk("arst.t", core_t_o, 0);
    chk("arst.slen", core_s_len_o, 0); chk("arst.tlen", core_t_len_o, 0);
    chk("arst.score", score_o, 0);    chk("arst.state", dbg_state_o, ST_IDLE);
    repeat (2) step();
    reset_i = 1'b1;
    step();
    run(4, 6, 16'd21, '1, 1'b0, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_feeder.md
# seq_feeder

Upstream stage of the Smith-Waterman `core`. It fetches the query (S) and database (T) sequences from the sequence SRAM (8192×8, one symbol per byte) and streams them into `core` one symbol per cycle: S first, then T, paced by `core`'s `t_valid_in`. After the stream it waits for `core` to report a result and latches the max score for the host. Each run is one `start_i` → `done_o` transaction.

## Interface
- `N`, 50: systolic PE count; maximum legal S length.
- `S_BASE`, 13'd0: SRAM byte address of S symbol 0.
- `T_BASE`, 13'd64: SRAM byte address of T symbol 0.
- `clk` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle run request; sampled only in IDLE.
- `s_len_i` in 16: S length; sampled on accepted start.
- `t_len_i` in 16: T length; sampled on accepted start.
- `mem_ce_o` out 1: SRAM read enable.
- `mem_addr_o` out 13: SRAM address.
- `mem_rdata_i` in 8: SRAM data, 1-cycle latency; symbol in bits [2:0].
- `core_clr_o` out 1: active-high one-cycle clear to `core` at run start.
- `core_s_o` out 3: S symbol to `core`; 3'd0 means no symbol.
- `core_t_o` out 3: T symbol to `core`; 3'd0 means no symbol.
- `core_s_len_o` out 16: latched S length, stable for the whole run.
- `core_t_len_o` out 16: latched T length, stable for the whole run.
- `core_t_valid_in_i` in 1: `core` can accept T.
- `core_busy_i` in 1: `core` busy.
- `core_valid_i` in 1: `core` result valid.
- `core_max_i` in 16: `core` max score.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky illegal-length flag; cleared by the next accepted start.
- `score_o` out 16: latched max score; held until the next done.

## Operation
- Symbol codes are 1–4 (A, C, G, T). Code 0 is reserved for idle on both symbol buses. Any 0 read from SRAM is forwarded unchanged; the bench must not store it.
- FSM states: IDLE, CLR, LOAD_S, WAIT_T, LOAD_T, DRAIN, WAIT_RES, DONE.
- IDLE, on `start_i`:
  - If `s_len_i` = 0, `s_len_i` > N, or `t_len_i` = 0: set `err_o` and stay in IDLE. No `done_o`.
  - Otherwise: latch both lengths, clear `err_o`, go to CLR.
- CLR: assert `core_clr_o` for 1 cycle, then go to LOAD_S.
- LOAD_S:
  - Issue one read per cycle at `S_BASE`+i, i = 0..s_len−1.
  - After the last read, go to WAIT_T.
- WAIT_T: wait for `core_t_valid_in_i`=1, then go to LOAD_T.
- LOAD_T:
  - Issue a read at `T_BASE`+j only in cycles where `core_t_valid_in_i`=1. Otherwise hold j and drop `mem_ce_o`.
  - After the read with j = t_len−1, go to DRAIN.
- DRAIN: one cycle for the last in-flight symbol, then go to WAIT_RES.
- WAIT_RES:
  - On `core_valid_i`=1 with `core_busy_i`=0: latch `core_max_i` into `score_o` and go to DONE.
- DONE: pulse `done_o` for 1 cycle, then go to IDLE.
- Index counters are 16 bits. The address is base + index truncated to 13 bits; it wraps at 8192 with no error.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values:
  - FSM: IDLE.
  - `mem_ce_o`, `core_clr_o`, `done_o`, `err_o`, `busy_o`: 0.
  - `mem_addr_o`, `core_s_o`, `core_t_o`, lengths, `score_o`: 0.
- Read latency: a read issued in cycle k puts its symbol on `core_s_o`/`core_t_o` in cycle k+1, registered.
  - The symbol appears for exactly 1 cycle; the bus is 0 otherwise.
  - S and T are never nonzero in the same cycle.
- Fast path: start in cycle 0 gives CLR in cycle 1 and S symbol 0 in cycle 3.
  - S occupies cycles 3..2+s_len.
- T backpressure: `core_t_valid_in_i` is sampled in the issue cycle.
  - A read already in flight when it drops is still delivered the next cycle.
  - `core` must accept at most one such symbol.
- A `core_valid_i` seen before WAIT_RES is ignored.
- Reset assertion in any state aborts the run immediately. `score_o` is cleared.

## Structure
- Shared package `sw_pkg`:
  - symbol code constants: `SYM_NONE`=0, `SYM_A`..`SYM_T`=1..4;
  - FSM state enum;
  - address width 13 and score width 16.
- The address generator is one natural sub-module, `seq_addr_gen`. It handles base, index, enable and last-flag, and is instantiated once and re-based between S and T.

## Test plan
- s_len=4, t_len=6, `core_t_valid_in_i` tied 1, SRAM S=1,2,3,4 and T=4,3,2,1,1,2:
  - `core_s_o` shows 1,2,3,4 in cycles 3–6;
  - T appears on consecutive cycles;
  - `core_valid_i` with max=7 gives `score_o`=7 and a single `done_o` pulse.
- Toggle `core_t_valid_in_i` 1,0,0,1 during LOAD_T: T addresses hold while it is low, exactly one in-flight symbol arrives after the drop, and no symbol is lost or duplicated.
- s_len=51 → `err_o`=1, `busy_o` stays 0, no SRAM read. A following legal start clears `err_o`.
- `start_i` pulsed again mid-LOAD_S: ignored, and the latched lengths are unchanged.
- `T_BASE`=8190, t_len=4 → addresses 8190, 8191, 0, 1.
- Reset asserted in LOAD_T: all outputs go to reset values asynchronously. A new start then runs a full transaction correctly.
